// File: rtl/vga_timing_overlay_gen_if.sv
// Pixel-side bundle of the VGA timing/overlay generator: frame-buffer pixels,
// fetch request, VGA outputs, active-area coordinates and overlay box controls.
interface vga_timing_overlay_gen_if #(
    parameter int unsigned DW   = 10,
    parameter int unsigned CW   = 12,
    parameter int unsigned NBOX = 2
);
    logic [DW-1:0]      iRed;
    logic [DW-1:0]      iGreen;
    logic [DW-1:0]      iBlue;
    logic               oRequest;
    logic [DW-1:0]      oVGA_R;
    logic [DW-1:0]      oVGA_G;
    logic [DW-1:0]      oVGA_B;
    logic               oVGA_H_SYNC;
    logic               oVGA_V_SYNC;
    logic               oVGA_BLANK;
    logic               oVGA_SYNC;
    logic [CW-1:0]      oX;
    logic [CW-1:0]      oY;
    logic               oFrameStart;
    logic [NBOX-1:0]    iBOX_EN;
    logic [NBOX-1:0]    iBOX_FILL;
    logic [NBOX*CW-1:0] iBOX_X1;
    logic [NBOX*CW-1:0] iBOX_Y1;
    logic [NBOX*CW-1:0] iBOX_X2;
    logic [NBOX*CW-1:0] iBOX_Y2;
    logic [NBOX*DW-1:0] iBOX_R;
    logic [NBOX*DW-1:0] iBOX_G;
    logic [NBOX*DW-1:0] iBOX_B;

    // Frame-buffer / host side
    modport master (
        output iRed, iGreen, iBlue,
        input  oRequest,
        input  oVGA_R, oVGA_G, oVGA_B,
        input  oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC,
        input  oX, oY, oFrameStart,
        output iBOX_EN, iBOX_FILL,
        output iBOX_X1, iBOX_Y1, iBOX_X2, iBOX_Y2,
        output iBOX_R, iBOX_G, iBOX_B
    );

    // Timing generator side
    modport slave (
        input  iRed, iGreen, iBlue,
        output oRequest,
        output oVGA_R, oVGA_G, oVGA_B,
        output oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC,
        output oX, oY, oFrameStart,
        input  iBOX_EN, iBOX_FILL,
        input  iBOX_X1, iBOX_Y1, iBOX_X2, iBOX_Y2,
        input  iBOX_R, iBOX_G, iBOX_B
    );
endinterface

// File: rtl/vga_timing_overlay_gen.sv
// Parametrised VGA timing generator with NBOX overlay rectangles, frame-start shadowed.
// Optional macro VGA_TEST_PATTERN_EN adds iPATTERN, which swaps input pixels for 8 colour bars.
module vga_timing_overlay_gen #(
    parameter int unsigned DW           = 10,
    parameter int unsigned CW           = 12,
    parameter int unsigned H_SYNC_CYC   = 96,
    parameter int unsigned H_SYNC_BACK  = 48,
    parameter int unsigned H_SYNC_ACT   = 640,
    parameter int unsigned H_SYNC_FRONT = 16,
    parameter int unsigned V_SYNC_CYC   = 2,
    parameter int unsigned V_SYNC_BACK  = 33,
    parameter int unsigned V_SYNC_ACT   = 480,
    parameter int unsigned V_SYNC_FRONT = 10,
    parameter int unsigned SYNC_POL     = 0,
    parameter int unsigned REQ_LEAD     = 2,
    parameter int unsigned NBOX         = 2
) (
    input  logic iCLK,
    input  logic iRST,
`ifdef VGA_TEST_PATTERN_EN
    input  logic iPATTERN,
`endif
    vga_timing_overlay_gen_if.slave vga
);
    localparam int unsigned H_TOTAL   = H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT;
    localparam int unsigned V_TOTAL   = V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT;
    localparam int unsigned X_START   = H_SYNC_CYC + H_SYNC_BACK;
    localparam int unsigned X_END     = X_START + H_SYNC_ACT;
    localparam int unsigned Y_START   = V_SYNC_CYC + V_SYNC_BACK;
    localparam int unsigned Y_END     = Y_START + V_SYNC_ACT;
    localparam int unsigned REQ_START = X_START - REQ_LEAD;
    localparam int unsigned REQ_END   = X_END - REQ_LEAD;
    localparam logic        SYNC_LVL  = (SYNC_POL != 0);

    logic [CW-1:0] hCont;
    logic [CW-1:0] vCont;
    logic          hWrap;
    logic          vWrap;
    logic          frameTop;
    logic          hActive;
    logic          vActive;
    logic          active;
    logic          reqWin;
    logic [CW-1:0] px;
    logic [CW-1:0] py;

    logic [NBOX-1:0]    shEn;
    logic [NBOX-1:0]    shFill;
    logic [NBOX*CW-1:0] shX1;
    logic [NBOX*CW-1:0] shY1;
    logic [NBOX*CW-1:0] shX2;
    logic [NBOX*CW-1:0] shY2;
    logic [NBOX*DW-1:0] shR;
    logic [NBOX*DW-1:0] shG;
    logic [NBOX*DW-1:0] shB;

    logic          boxHit;
    logic [DW-1:0] boxR;
    logic [DW-1:0] boxG;
    logic [DW-1:0] boxB;
    logic [DW-1:0] srcR;
    logic [DW-1:0] srcG;
    logic [DW-1:0] srcB;

    // Raster position counters
    assign hWrap    = (hCont == CW'(H_TOTAL - 1));
    assign vWrap    = (vCont == CW'(V_TOTAL - 1));
    assign frameTop = (hCont == '0) && (vCont == '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hCont <= '0;
            vCont <= '0;
        end else if (hWrap) begin
            hCont <= '0;
            vCont <= vWrap ? '0 : vCont + CW'(1);
        end else begin
            hCont <= hCont + CW'(1);
        end
    end

    // Region decode on the current counter state
    assign hActive = (hCont >= CW'(X_START)) && (hCont < CW'(X_END));
    assign vActive = (vCont >= CW'(Y_START)) && (vCont < CW'(Y_END));
    assign active  = hActive && vActive;
    assign reqWin  = (hCont >= CW'(REQ_START)) && (hCont < CW'(REQ_END));
    assign px      = hCont - CW'(X_START);
    assign py      = vCont - CW'(Y_START);

    // Box registers only move at the top of a frame so a frame never tears
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shEn   <= '0;
            shFill <= '0;
            shX1   <= '0;
            shY1   <= '0;
            shX2   <= '0;
            shY2   <= '0;
            shR    <= '0;
            shG    <= '0;
            shB    <= '0;
        end else if (frameTop) begin
            shEn   <= vga.iBOX_EN;
            shFill <= vga.iBOX_FILL;
            shX1   <= vga.iBOX_X1;
            shY1   <= vga.iBOX_Y1;
            shX2   <= vga.iBOX_X2;
            shY2   <= vga.iBOX_Y2;
            shR    <= vga.iBOX_R;
            shG    <= vga.iBOX_G;
            shB    <= vga.iBOX_B;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_SYNC_ACT >= 8) ? H_SYNC_ACT / 8 : 1;
    logic [CW-1:0] barIdx;
    logic [2:0]    bar;
`endif

    // Underlying pixel: frame buffer, or colour bars when the pattern is selected
    always_comb begin
        srcR = vga.iRed;
        srcG = vga.iGreen;
        srcB = vga.iBlue;
`ifdef VGA_TEST_PATTERN_EN
        barIdx = px / CW'(BAR_W);
        bar    = (barIdx > CW'(7)) ? 3'd7 : barIdx[2:0];
        if (iPATTERN) begin
            srcR = {DW{~bar[1]}};
            srcG = {DW{~bar[2]}};
            srcB = {DW{~bar[0]}};
        end
`endif
    end

    // Walk from the highest box down so the lowest-index hit wins
    always_comb begin
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
        logic [CW-1:0] x2;
        logic [CW-1:0] y2;
        logic          inX;
        logic          inY;
        logic          onX;
        logic          onY;
        logic          hit;
        boxHit = 1'b0;
        boxR   = '0;
        boxG   = '0;
        boxB   = '0;
        x1     = '0;
        y1     = '0;
        x2     = '0;
        y2     = '0;
        inX    = 1'b0;
        inY    = 1'b0;
        onX    = 1'b0;
        onY    = 1'b0;
        hit    = 1'b0;
        for (int k = int'(NBOX) - 1; k >= 0; k--) begin
            x1  = shX1[k*CW +: CW];
            y1  = shY1[k*CW +: CW];
            x2  = shX2[k*CW +: CW];
            y2  = shY2[k*CW +: CW];
            inX = (px >= x1) && (px <= x2);
            inY = (py >= y1) && (py <= y2);
            onX = (px == x1) || (px == x2);
            onY = (py == y1) || (py == y2);
            hit = shEn[k] && (x1 <= x2) && (y1 <= y2) &&
                  (shFill[k] ? (inX && inY) : ((onX && inY) || (onY && inX)));
            if (hit) begin
                boxHit = 1'b1;
                boxR   = shR[k*DW +: DW];
                boxG   = shG[k*DW +: DW];
                boxB   = shB[k*DW +: DW];
            end
        end
    end

    // Single output register stage keeps sync, blank, RGB and coordinates aligned
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vga.oVGA_H_SYNC <= 1'b0;
            vga.oVGA_V_SYNC <= 1'b0;
            vga.oVGA_BLANK  <= 1'b0;
            vga.oRequest    <= 1'b0;
            vga.oFrameStart <= 1'b0;
            vga.oX          <= '0;
            vga.oY          <= '0;
            vga.oVGA_R      <= '0;
            vga.oVGA_G      <= '0;
            vga.oVGA_B      <= '0;
        end else begin
            vga.oVGA_H_SYNC <= (hCont < CW'(H_SYNC_CYC)) ? SYNC_LVL : ~SYNC_LVL;
            vga.oVGA_V_SYNC <= (vCont < CW'(V_SYNC_CYC)) ? SYNC_LVL : ~SYNC_LVL;
            vga.oVGA_BLANK  <= active;
            vga.oRequest    <= vActive && reqWin;
            vga.oFrameStart <= frameTop;
            if (active) begin
                vga.oX     <= px;
                vga.oY     <= py;
                vga.oVGA_R <= boxHit ? boxR : srcR;
                vga.oVGA_G <= boxHit ? boxG : srcG;
                vga.oVGA_B <= boxHit ? boxB : srcB;
            end else begin
                vga.oVGA_R <= '0;
                vga.oVGA_G <= '0;
                vga.oVGA_B <= '0;
            end
        end
    end

    assign vga.oVGA_SYNC = 1'b0;

endmodule
